// File: rtl/imem_loader_pkg.sv
// Shared fetch/loader definitions: default memory geometry and loader state encoding.
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int AW_DEFAULT    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-load stream, fetch port and status bundle; master drives requests, slave is the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int AW = AW_DEFAULT
);
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_instr;
  logic          stall_req;
  logic          load_busy;
  logic          load_done;
  logic          err_clamp;

  modport master (
    output start, word_count, byte_valid, byte_data, fetch_addr,
    input  byte_ready, fetch_instr, stall_req, load_busy, load_done, err_clamp
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data, fetch_addr,
    output byte_ready, fetch_instr, stall_req, load_busy, load_done, err_clamp
  );
endinterface

// File: rtl/imem_wr.sv
// Instruction storage: one synchronous write port, one zero-latency combinational read port.
// Contents are deliberately left out of reset so a reset never wipes a loaded program.
module imem_wr
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Serial byte loader into instruction memory; fetch reads are combinational outside LOAD.
// One byte per cycle when byte_ready, no back-pressure within a session; start ignored during LOAD.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.slave bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  load_state_t state, state_nxt;
  logic [AW:0] word_target;
  logic [AW:0] words_done;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        err_q;
  logic        start_ok;
  logic        xfer;
  logic        word_end;
  logic        last_word;
  logic [AW:0] clamped;
  logic [31:0] rd_data;

  assign clamped   = (bus.word_count > DEPTH_W) ? DEPTH_W : bus.word_count;
  assign start_ok  = bus.start && (state != LOAD);
  assign xfer      = bus.byte_valid && (state == LOAD);
  assign word_end  = xfer && (byte_idx == 2'd3);
  assign last_word = ((words_done + ONE_W) == word_target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.byte_ready  = 1'b0;
    bus.stall_req   = 1'b0;
    bus.load_busy   = 1'b0;
    bus.load_done   = 1'b0;
    bus.fetch_instr = rd_data;
    case (state)
      IDLE, DONE: begin
        bus.load_done = (state == DONE);
        if (bus.start) state_nxt = (bus.word_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        bus.byte_ready  = 1'b1;
        bus.stall_req   = 1'b1;
        bus.load_busy   = 1'b1;
        bus.fetch_instr = 32'h0000_0000;
        if (word_end && last_word) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The 4th byte never lands in partial: it goes straight into the memory write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_target <= '0;
      words_done  <= '0;
      byte_idx    <= 2'd0;
      partial     <= 24'h0;
      err_q       <= 1'b0;
    end else if (start_ok) begin
      word_target <= clamped;
      words_done  <= '0;
      byte_idx    <= 2'd0;
      partial     <= 24'h0;
      err_q       <= (bus.word_count > DEPTH_W);
    end else if (xfer) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    partial[7:0]   <= bus.byte_data;
        2'd1:    partial[15:8]  <= bus.byte_data;
        2'd2:    partial[23:16] <= bus.byte_data;
        default: begin
          partial    <= 24'h0;
          words_done <= words_done + ONE_W;
        end
      endcase
    end
  end

  assign bus.err_clamp = err_q;

  imem_wr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (word_end),
    .waddr (words_done[AW-1:0]),
    .wdata ({bus.byte_data, partial}),
    .raddr (bus.fetch_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vectors, directed corner sequences and random traffic vs a byte-level model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_busy, m_done, m_err;
  int          m_target, m_bytes;
  logic [7:0]  m_q [$];

  typedef struct {
    bit          st;
    int          wc;
    bit          bv;
    int          bd;
    int          fa;
    bit          e_busy;
    bit          e_done;
    bit          chk_i;
    logic [31:0] e_i;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int fa;
    fa = int'(bus.fetch_addr);
    chk("byte_ready", {31'b0, bus.byte_ready}, {31'b0, m_busy});
    chk("stall_req",  {31'b0, bus.stall_req},  {31'b0, m_busy});
    chk("load_busy",  {31'b0, bus.load_busy},  {31'b0, m_busy});
    chk("load_done",  {31'b0, bus.load_done},  {31'b0, m_done});
    chk("err_clamp",  {31'b0, bus.err_clamp},  {31'b0, m_err});
    if (m_busy) chk("fetch_nop", bus.fetch_instr, 32'h0);
    else if (m_known[fa]) chk($sformatf("fetch[%0d]", fa), bus.fetch_instr, m_mem[fa]);
  endtask

  // Model step at a rising edge: sessions counted in bytes, words formed from groups of four.
  task automatic model_edge();
    if (bus.start && !m_busy) begin
      m_target = (int'(bus.word_count) > DEPTH) ? DEPTH : int'(bus.word_count);
      m_err    = (int'(bus.word_count) > DEPTH);
      m_bytes  = 0;
      m_q.delete();
      m_busy   = (m_target != 0);
      m_done   = (m_target == 0);
    end else if (m_busy && bus.byte_valid) begin
      m_q.push_back(bus.byte_data);
      m_bytes++;
      if (m_q.size() == 4) begin
        m_mem[m_bytes/4 - 1]   = {m_q[3], m_q[2], m_q[1], m_q[0]};
        m_known[m_bytes/4 - 1] = 1'b1;
        m_q.delete();
      end
      if (m_bytes == 4 * m_target) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic apply(input bit st, input int wc, input bit bv, input int bd, input int fa);
    bus.start      = st;
    bus.word_count = (AW+1)'(wc);
    bus.byte_valid = bv;
    bus.byte_data  = 8'(bd);
    bus.fetch_addr = AW'(fa);
    #1;
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic cyc(input bit st, input int wc, input bit bv, input int bd, input int fa);
    apply(st, wc, bv, bd, fa);
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst byte_ready", {31'b0, bus.byte_ready}, 32'h0);
    chk("rst stall_req",  {31'b0, bus.stall_req},  32'h0);
    chk("rst load_busy",  {31'b0, bus.load_busy},  32'h0);
    chk("rst load_done",  {31'b0, bus.load_done},  32'h0);
    chk("rst err_clamp",  {31'b0, bus.err_clamp},  32'h0);
    m_busy = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic read_const(input string name, input int fa, input logic [31:0] exp);
    apply(1'b0, 0, 1'b0, 0, fa);
    chk(name, bus.fetch_instr, exp);
    advance();
  endtask

  initial begin
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h00, 8'h02, 8'h20, 8'h14, 8'h00, 8'h03, 8'h20};

    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_busy = 0; m_done = 0; m_err = 0; m_target = 0; m_bytes = 0;
    reset = 1'b0;
    bus.start = 0; bus.word_count = '0; bus.byte_valid = 0; bus.byte_data = '0; bus.fetch_addr = '0;
    #2;
    do_reset();

    // Back-to-back two-word load, checked against fixed expectations.
    vecs[0] = '{1, 2, 0, 0, 0, 0, 0, 0, 32'h0};
    for (int i = 0; i < 8; i++) vecs[i+1] = '{0, 0, 1, int'(prog[i]), 0, 1, 0, 1, 32'h0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 32'h2002_0013};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 1, 1, 32'h2003_0014};
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].st, vecs[i].wc, vecs[i].bv, vecs[i].bd, vecs[i].fa);
      chk($sformatf("vec%0d busy", i), {31'b0, bus.load_busy}, {31'b0, vecs[i].e_busy});
      chk($sformatf("vec%0d done", i), {31'b0, bus.load_done}, {31'b0, vecs[i].e_done});
      if (vecs[i].chk_i) chk($sformatf("vec%0d instr", i), bus.fetch_instr, vecs[i].e_i);
      advance();
    end

    // Overwrite with junk, then reload with 3-cycle gaps between bytes.
    cyc(1, 2, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, $urandom_range(0, 255), 0);
    cyc(1, 2, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, int'(prog[i]), 0);
      for (int g = 0; g < 3 && i < 7; g++) cyc(0, 0, 0, $urandom_range(0, 255), $urandom_range(0, 63));
    end
    read_const("gap mem0", 0, 32'h2002_0013);
    read_const("gap mem1", 1, 32'h2003_0014);

    // Zero-length session: straight to DONE, bytes refused, memory untouched.
    cyc(1, 0, 0, 0, 0);
    apply(0, 0, 1, 8'hFF, 0);
    chk("wc0 done",  {31'b0, bus.load_done},  32'h1);
    chk("wc0 ready", {31'b0, bus.byte_ready}, 32'h0);
    advance();
    cyc(0, 0, 1, 8'hEE, 1);
    read_const("wc0 mem0", 0, 32'h2002_0013);

    // Exactly DEPTH words is legal; beyond DEPTH clamps and flags.
    cyc(1, DEPTH, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    chk("wc64 err", {31'b0, bus.err_clamp}, 32'h0);
    advance();
    for (int i = 0; i < 4 * DEPTH; i++) cyc(0, 0, 1, $urandom_range(0, 255), 0);
    cyc(1, 100, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    chk("clamp err", {31'b0, bus.err_clamp}, 32'h1);
    advance();
    for (int i = 0; i < 256; i++) cyc(0, 0, 1, $urandom_range(0, 255), 0);
    apply(0, 0, 1, 8'h5A, 0);
    chk("clamp done", {31'b0, bus.load_done}, 32'h1);
    chk("clamp busy", {31'b0, bus.load_busy}, 32'h0);
    advance();
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, $urandom_range(0, 255), 0);
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 0, a);

    // Reset after 5 bytes: word 0 kept, word 1 untouched, next session starts at 0.
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 8'hAA, 0);
    cyc(0, 0, 1, 8'hBB, 0);
    cyc(0, 0, 1, 8'hCC, 0);
    cyc(0, 0, 1, 8'hDD, 0);
    apply(0, 0, 1, 8'hEE, 0);
    advance();
    do_reset();
    read_const("rst mem0", 0, 32'hDDCC_BBAA);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, i, 0);
    read_const("restart mem0", 0, 32'h0403_0201);
    cyc(0, 0, 0, 0, 1);

    // A start pulse mid-load is ignored; fetch is live in the same cycle as DONE.
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 0, 1, 8'h12, 0);
    apply(1, 1, 1, 8'h13, 0);
    chk("ign busy", {31'b0, bus.load_busy}, 32'h1);
    advance();
    for (int i = 4; i <= 8; i++) cyc(0, 0, 1, 8'h10 + i, 0);
    read_const("ign mem1", 1, 32'h1817_1615);
    read_const("ign mem0", 0, 32'h1413_1211);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit st;
      int wc;
      int r;
      st = m_busy ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 15);
      r  = $urandom_range(0, 9);
      wc = (r < 7) ? $urandom_range(0, 6) : (r < 9) ? $urandom_range(7, 20) : $urandom_range(0, 127);
      cyc(st, wc, $urandom_range(0, 99) < 60, $urandom_range(0, 255), $urandom_range(0, 63));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, meaning number of 32-bit instruction words held.
REQ-002 Parameter AW, default 6, meaning word address width, log2(DEPTH).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 word_count  input  AW+1  number of words to load, sampled when start is accepted.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  serial program byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready.
REQ-010 fetch_addr  input  AW  word address from the fetch stage (PC[AW+1:2]).
REQ-011 fetch_instr  output  32  instruction word returned to the fetch stage.
REQ-012 stall_req  output  1  request to hold the PC register (feeds stallF).
REQ-013 load_busy  output  1  a load session is in progress.
REQ-014 load_done  output  1  most recent session completed.
REQ-015 err_clamp  output  1  word_count exceeded DEPTH and was clamped.

Function
REQ-016 The module SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-017 IDLE->LOAD on start when word_count != 0; IDLE->DONE on start when word_count == 0.
REQ-018 LOAD->DONE the cycle after the final byte of word word_count-1 is accepted.
REQ-019 DONE->LOAD or DONE->DONE on start, using the same rules as IDLE; start in LOAD SHALL be ignored.
REQ-020 On accepted start, word_count > DEPTH SHALL be clamped to DEPTH, with err_clamp set until the next accepted start.
REQ-021 byte_ready SHALL be 1 only in LOAD; no back-pressure inside LOAD (one byte per cycle max).
REQ-022 Bytes SHALL assemble little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-023 On acceptance of the 4th byte, the full word SHALL be written to address wr_addr at that clock edge, and wr_addr SHALL increment.
REQ-024 wr_addr and byte index SHALL restart at 0 on every accepted start.
REQ-025 Cycles without byte_valid SHALL leave the partial word and counters unchanged.
REQ-026 fetch_instr SHALL be a combinational read of memory[fetch_addr] in IDLE and DONE, with zero-cycle latency.
REQ-027 fetch_instr SHALL be 32'h00000000 (nop) while in LOAD.
REQ-028 Same-cycle write and read to one address outside LOAD is impossible; the write lands at the edge and is visible combinationally after it.
REQ-029 stall_req = load_busy = (state == LOAD); load_done = (state == DONE).
REQ-030 Memory words not written in a session SHALL retain prior contents.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE, wr_addr = 0, byte index = 0, partial word = 0, err_clamp = 0, load_done = 0, load_busy = 0, stall_req = 0, byte_ready = 0.
REQ-032 Reset mid-LOAD SHALL abort the session; words already written remain, and the partial word is discarded.
REQ-033 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-034 State encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and the default DEPTH/AW SHALL live in a shared package/include used by fetch and loader.
REQ-035 The storage SHALL be a sub-module imem_wr: 1 sync write port and 1 async read port; the FSM, assembler and counters stay in imem_loader.

Verification
REQ-036 Reset, start, word_count=2, bytes 13,00,02,20,14,00,03,20 back-to-back -> mem[0]=32'h20020013, mem[1]=32'h20030014; load_done=1 on the cycle after the 8th byte.
REQ-037 Same load with byte_valid gaps of 3 cycles between bytes -> identical memory contents; stall_req=1 throughout LOAD; fetch_instr=0 in LOAD.
REQ-038 start with word_count=0 -> DONE next cycle, byte_ready never 1, memory unchanged.
REQ-039 start with word_count=100 (DEPTH=64) -> err_clamp=1; exactly 64 words written; DONE after byte 256.
REQ-040 reset asserted after 5 bytes of a 2-word load -> IDLE immediately, mem[0] written, mem[1] unchanged; new session restarts at address 0.
REQ-041 start pulse during LOAD -> ignored; after DONE, fetch_addr=1 -> fetch_instr=mem[1] in the same cycle.
